// File: rtl/jtag_tap_ctrl_pkg.sv
// Shared definitions for the JTAG TAP controller: TAP state encodings,
// instruction opcodes and the instruction-class decode helpers.
package jtag_tap_ctrl_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR  = 4'h0,
        EXIT1_DR  = 4'h1,
        SHIFT_DR  = 4'h2,
        PAUSE_DR  = 4'h3,
        SEL_IR    = 4'h4,
        UPDATE_DR = 4'h5,
        CAP_DR    = 4'h6,
        SEL_DR    = 4'h7,
        EXIT2_IR  = 4'h8,
        EXIT1_IR  = 4'h9,
        SHIFT_IR  = 4'hA,
        PAUSE_IR  = 4'hB,
        RTI       = 4'hC,
        UPDATE_IR = 4'hD,
        CAP_IR    = 4'hE,
        TLR       = 4'hF
    } tap_state_e;

    localparam logic [3:0] INSTR_EXTEST         = 4'h0;
    localparam logic [3:0] INSTR_SAMPLE_PRELOAD = 4'h1;
    localparam logic [3:0] INSTR_IDCODE         = 4'h2;
    localparam logic [3:0] INSTR_BYPASS         = 4'hF;

    localparam logic [3:0] IR_CAPTURE_VAL       = 4'b0001;

    function automatic logic is_bsr_instr(input logic [3:0] instr);
        return (instr == INSTR_EXTEST) || (instr == INSTR_SAMPLE_PRELOAD);
    endfunction

    function automatic logic is_idcode_instr(input logic [3:0] instr);
        return instr == INSTR_IDCODE;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: registered state plus TMS-driven next-state logic.
module jtag_tap_fsm
    import jtag_tap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tms,
    output tap_state_e state
);

    // state            | meaning
    // TLR              | test logic reset, IR forced to IDCODE
    // RTI              | idle between scans
    // SEL_DR / SEL_IR  | choose data or instruction path
    // CAP / SHIFT      | parallel capture, then serial shift
    // EXIT1/PAUSE/EXIT2| leave shift, optionally hold with registers frozen
    // UPDATE           | commit shifted value

    tap_state_e state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TLR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            TLR:       state_next = tms ? TLR       : RTI;
            RTI:       state_next = tms ? SEL_DR    : RTI;
            SEL_DR:    state_next = tms ? SEL_IR    : CAP_DR;
            CAP_DR:    state_next = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:  state_next = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:  state_next = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:  state_next = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:  state_next = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR: state_next = tms ? SEL_DR    : RTI;
            SEL_IR:    state_next = tms ? TLR       : CAP_IR;
            CAP_IR:    state_next = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:  state_next = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:  state_next = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:  state_next = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:  state_next = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR: state_next = tms ? SEL_DR    : RTI;
            default:   state_next = TLR;
        endcase
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction register, IDCODE/bypass data registers,
// boundary-scan strobe decode and the falling-edge TDO mux.
module jtag_tap_ctrl
    import jtag_tap_ctrl_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_563D,
    parameter int          BSR_LEN    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tms,
    input  logic       tdi,
    output logic       tdo,
    output logic       tdo_en,
    output logic       bsr_si,
    input  logic       bsr_so,
    output logic       shift_dr,
    output logic       clk_dr,
    output logic       update_dr,
    output logic       mode,
    output logic [3:0] tap_state
);

    if (IR_W != 4) begin : g_bad_ir_w
        $error("jtag_tap_ctrl: opcodes are 4 bits wide, IR_W must be 4");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_tap_ctrl: IDCODE_VAL bit 0 must be 1");
    end
    if (BSR_LEN < 1) begin : g_bad_bsr_len
        $error("jtag_tap_ctrl: BSR_LEN must be at least 1");
    end

    tap_state_e      state;
    logic [IR_W-1:0] ir_shift;
    logic [IR_W-1:0] ir;
    logic [31:0]     idcode_sr;
    logic            bypass_reg;
    logic            sel_bsr;
    logic            sel_id;
    logic            tdo_next;
    logic            tdo_en_next;

    jtag_tap_fsm u_fsm (
        .clk   (clk),
        .rst_n (rst_n),
        .tms   (tms),
        .state (state)
    );

    assign tap_state = state;
    assign bsr_si    = tdi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_shift <= '0;
        end else if (state == CAP_IR) begin
            ir_shift <= IR_CAPTURE_VAL;
        end else if (state == SHIFT_IR) begin
            ir_shift <= {tdi, ir_shift[IR_W-1:1]};
        end
    end

    // mode is loaded alongside the IR so it only ever moves on UPDATE_IR or TLR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir   <= INSTR_IDCODE;
            mode <= 1'b0;
        end else if (state == TLR) begin
            ir   <= INSTR_IDCODE;
            mode <= 1'b0;
        end else if (state == UPDATE_IR) begin
            ir   <= ir_shift;
            mode <= (ir_shift == INSTR_EXTEST);
        end
    end

    // anything that is not BSR or IDCODE falls through to bypass
    always_comb begin
        sel_bsr = is_bsr_instr(ir);
        sel_id  = is_idcode_instr(ir);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idcode_sr <= '0;
        end else if (sel_id && state == CAP_DR) begin
            idcode_sr <= IDCODE_VAL;
        end else if (sel_id && state == SHIFT_DR) begin
            idcode_sr <= {tdi, idcode_sr[31:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_reg <= 1'b0;
        end else if (!sel_bsr && !sel_id && state == CAP_DR) begin
            bypass_reg <= 1'b0;
        end else if (!sel_bsr && !sel_id && state == SHIFT_DR) begin
            bypass_reg <= tdi;
        end
    end

    always_comb begin
        clk_dr    = sel_bsr && (state == CAP_DR || state == SHIFT_DR);
        shift_dr  = sel_bsr && (state == SHIFT_DR);
        update_dr = sel_bsr && (state == UPDATE_DR);
    end

    always_comb begin
        tdo_next    = 1'b0;
        tdo_en_next = 1'b0;
        if (state == SHIFT_IR) begin
            tdo_next    = ir_shift[0];
            tdo_en_next = 1'b1;
        end else if (state == SHIFT_DR) begin
            tdo_en_next = 1'b1;
            if (sel_bsr) begin
                tdo_next = bsr_so;
            end else if (sel_id) begin
                tdo_next = idcode_sr[0];
            end else begin
                tdo_next = bypass_reg;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo    <= tdo_next;
            tdo_en <= tdo_en_next;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl with an 8-deep boundary-scan chain model.
module tb_jtag_tap_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo, tdo_en, bsr_si, bsr_so;
    logic       shift_dr, clk_dr, update_dr, mode;
    logic [3:0] tap_state;

    int vectors = 0;
    int miscompares = 0;
    int n_clk_dr, n_shift_dr, n_update_dr;

    logic [31:0] idv     = 32'h1000_563D;
    logic [7:0]  cap_val = 8'hA5;
    logic [7:0]  pat     = 8'h3C;
    logic [3:0]  bp_pat  = 4'b1101;
    logic [7:0]  bsr_model;

    jtag_tap_ctrl #(.IR_W(4), .IDCODE_VAL(32'h1000_563D), .BSR_LEN(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .bsr_si    (bsr_si),
        .bsr_so    (bsr_so),
        .shift_dr  (shift_dr),
        .clk_dr    (clk_dr),
        .update_dr (update_dr),
        .mode      (mode),
        .tap_state (tap_state)
    );

    always #5 clk = ~clk;

    // chain of one_bsc cells: capture 8'hA5 in parallel, shift toward bsr_so
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bsr_model <= 8'h00;
        else if (clk_dr) bsr_model <= shift_dr ? {bsr_si, bsr_model[7:1]} : cap_val;
    end
    assign bsr_so = bsr_model[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic tally();
        n_clk_dr    += int'(clk_dr);
        n_shift_dr  += int'(shift_dr);
        n_update_dr += int'(update_dr);
    endtask

    // from RTI: load an instruction and return to RTI
    task automatic load_ir(input logic [3:0] code);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("ir_capture_bit0", {31'd0, tdo}, 32'd1);
        step(0, code[0]);
        chk("ir_capture_bit1", {31'd0, tdo}, 32'd0);
        step(0, code[1]);
        step(0, code[2]);
        step(1, code[3]);
        step(1, 0);
        step(0, 0);
    endtask

    initial begin
        // reset
        #2;
        @(negedge clk);
        #1;
        chk("rst_state", {28'd0, tap_state}, 32'hF);
        chk("rst_tdo_en", {31'd0, tdo_en}, 32'd0);
        chk("rst_strobes", {29'd0, shift_dr, clk_dr, update_dr}, 32'd0);
        chk("rst_mode", {31'd0, mode}, 32'd0);
        rst_n = 1'b1;

        // IDCODE readout straight after reset
        step(0, 0);
        chk("rti_state", {28'd0, tap_state}, 32'hC);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("id_tdo_en", {31'd0, tdo_en}, 32'd1);
        chk("id_no_bsr_strobe", {30'd0, shift_dr, clk_dr}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("idcode_bit%0d", i), {31'd0, tdo}, {31'd0, idv[i]});
            step((i == 31), 0);
        end
        chk("exit1_tdo_en", {31'd0, tdo_en}, 32'd0);
        step(1, 0);
        step(0, 0);

        // BYPASS: one cycle of delay after the captured 0
        load_ir(4'hF);
        chk("bypass_mode", {31'd0, mode}, 32'd0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("bypass_tdo0", {31'd0, tdo}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, bp_pat[i]);
            chk($sformatf("bypass_tdo%0d", i + 1), {31'd0, tdo}, {31'd0, bp_pat[i]});
        end
        step(1, 0);
        step(1, 0);
        step(0, 0);

        // undefined opcode behaves as bypass
        load_ir(4'h7);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("undef_tdo0", {31'd0, tdo}, 32'd0);
        chk("undef_no_strobe", {30'd0, shift_dr, clk_dr}, 32'd0);
        step(0, 1);
        chk("undef_tdo1", {31'd0, tdo}, 32'd1);
        step(1, 0);
        step(1, 0);
        step(0, 0);

        // EXTEST: capture, 8 shifts, update
        load_ir(4'h0);
        chk("extest_mode", {31'd0, mode}, 32'd1);
        n_clk_dr = 0; n_shift_dr = 0; n_update_dr = 0;
        step(1, 0); tally();
        step(0, 0); tally();
        chk("cap_dr_state", {28'd0, tap_state}, 32'h6);
        chk("cap_dr_strobes", {30'd0, clk_dr, shift_dr}, 32'b10);
        step(0, 0); tally();
        chk("bsr_tdo0", {31'd0, tdo}, {31'd0, cap_val[0]});
        for (int i = 0; i < 8; i++) begin
            step((i == 7), pat[i]); tally();
            if (i < 7) chk($sformatf("bsr_tdo%0d", i + 1), {31'd0, tdo}, {31'd0, cap_val[i + 1]});
        end
        chk("bsr_shifted_in", {24'd0, bsr_model}, {24'd0, pat});
        step(1, 0); tally();
        chk("update_dr_pulse", {31'd0, update_dr}, 32'd1);
        step(0, 0); tally();
        chk("update_dr_low", {31'd0, update_dr}, 32'd0);
        chk("clk_dr_cycles", n_clk_dr, 32'd9);
        chk("shift_dr_cycles", n_shift_dr, 32'd8);
        chk("update_dr_cycles", n_update_dr, 32'd1);

        // reset in the middle of an EXTEST shift
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        chk("pre_rst_shift", {28'd0, tap_state}, 32'h2);
        rst_n = 1'b0;
        #2;
        chk("midrst_state", {28'd0, tap_state}, 32'hF);
        chk("midrst_tdo", {30'd0, tdo_en, tdo}, 32'd0);
        chk("midrst_strobes", {29'd0, shift_dr, clk_dr, update_dr}, 32'd0);
        chk("midrst_mode", {31'd0, mode}, 32'd0);
        #1;
        rst_n = 1'b1;
        step(0, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("midrst_ir_idcode", {30'd0, tdo, shift_dr}, 32'b10);
        step(1, 0);
        step(1, 0);
        step(0, 0);

        // TMS high for five edges from RTI
        load_ir(4'h0);
        chk("tms5_pre_mode", {31'd0, mode}, 32'd1);
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tms5_state", {28'd0, tap_state}, 32'hF);
        chk("tms5_mode", {31'd0, mode}, 32'd0);
        step(0, 0);
        chk("tms5_rti", {28'd0, tap_state}, 32'hC);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("tms5_ir_idcode", {30'd0, tdo, shift_dr}, 32'b10);
        step(1, 0);
        step(1, 0);
        step(0, 0);

        // SAMPLE_PRELOAD with a pause mid-shift
        load_ir(4'h1);
        chk("sp_mode", {31'd0, mode}, 32'd0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        chk("sp_tdo0", {31'd0, tdo}, {31'd0, cap_val[0]});
        for (int i = 1; i < 4; i++) begin
            step(0, 0);
            chk($sformatf("sp_tdo%0d", i), {31'd0, tdo}, {31'd0, cap_val[i]});
        end
        step(1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1);
            chk($sformatf("pause%0d_state", i), {28'd0, tap_state}, 32'h3);
            chk($sformatf("pause%0d_clk_dr", i), {30'd0, clk_dr, tdo_en}, 32'd0);
            chk($sformatf("pause%0d_frozen", i), {24'd0, bsr_model}, 32'h0A);
            chk($sformatf("pause%0d_mode", i), {31'd0, mode}, 32'd0);
        end
        step(1, 0);
        step(0, 0);
        chk("resume_tdo0", {31'd0, tdo}, 32'd0);
        step(0, 0);
        chk("resume_tdo1", {31'd0, tdo}, 32'd1);
        step(1, 0);
        step(1, 0);
        chk("sp_update", {31'd0, update_dr}, 32'd1);
        step(0, 0);
        chk("sp_end_mode", {31'd0, mode}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
